uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter clks_per_bit, default 216: bit period minus one, in clock cycles (25 MHz / 115200 baud).
REQ-002 Parameter fifo_depth, default 4: receive FIFO entries; SHALL be a power of two, at least 2.
REQ-003 Port clock, input, 1: single clock, rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-low reset.
REQ-005 Port rx, input, 1: serial line, idle high, asynchronous to clock.
REQ-006 Port data_valid, output, 1: FIFO non-empty.
REQ-007 Port data, output, 8: byte at the FIFO head.
REQ-008 Port data_ready, input, 1: consumer accepts the head byte.
REQ-009 Port frame_err, output, 1: one-cycle pulse when the stop bit is sampled low.
REQ-010 Port overrun, output, 1: one-cycle pulse when a valid byte is dropped because the FIFO is full.

Function
REQ-011 rx SHALL pass through a 2-flop synchronizer; all decisions SHALL use the synchronized value rxs.
REQ-012 Frame format SHALL be 8N1: start bit 0, 8 data bits LSB first, one stop bit 1.
REQ-013 FSM states SHALL be IDLE, START, DATA and STOP, with a cycle counter of width ceil(log2(clks_per_bit+1)).
REQ-014 IDLE: when rxs==0, clear the counter and go to START.
REQ-015 START: when counter==clks_per_bit/2 (integer division, 108 at default), go to DATA if rxs==0, otherwise go to IDLE (glitch rejection, no outputs); clear the counter in both cases.
REQ-016 DATA: when counter==clks_per_bit, sample rxs into the shift register MSB and shift right, clear the counter, and increment the bit index; after the 8th sample go to STOP.
REQ-017 STOP: when counter==clks_per_bit, sample rxs and go to IDLE in the same cycle.
REQ-018 Stop sample 1 with FIFO not full, or FIFO full with a pop in the same cycle: the shift register SHALL be written at the write pointer.
REQ-019 Stop sample 1 with FIFO full and no pop: the byte SHALL be discarded and overrun SHALL pulse for exactly 1 cycle.
REQ-020 Stop sample 0: the byte SHALL be discarded, frame_err SHALL pulse for 1 cycle, and the FIFO SHALL be unchanged.
REQ-021 data_valid SHALL go high in the cycle after the stop-sample edge (latency 1 cycle).
REQ-022 Pop SHALL occur only when data_valid && data_ready; data_ready while empty SHALL be ignored.
REQ-023 Pointers SHALL wrap modulo fifo_depth; the count SHALL range 0..fifo_depth.
REQ-024 On simultaneous push and pop, the count SHALL be unchanged and both pointers SHALL advance.
REQ-025 data SHALL equal the storage at the read pointer, driven from registers with no combinational path from rx.
REQ-026 FIFO order SHALL be preserved: first received is first out.
REQ-027 The sampling point SHALL be nominally mid-bit: start is confirmed at half period, and each later sample is one full period (clks_per_bit+1 cycles) after the previous one.

Reset
REQ-028 While reset==0: FSM=IDLE, counter=0, bit index=0, shift register=0, synchronizer flops=1, FIFO pointers and count=0, data_valid=0, frame_err=0, overrun=0.
REQ-029 Reset asserted mid-frame SHALL abort the frame and clear the FIFO; after release, reception SHALL restart on the next falling edge of rxs.
REQ-030 data SHALL read 8'h00 after reset, until the first push.

Verification
REQ-031 Drive 0x55 as 8N1 at 217 cycles/bit with data_ready=1 -> one data_valid pulse with data=0x55; frame_err=0; overrun=0.
REQ-032 Drive rx low for 50 cycles, then high -> FSM returns to IDLE; no data_valid, frame_err or overrun.
REQ-033 Drive 0xA3 with the stop bit held 0 -> one frame_err pulse; data_valid stays 0.
REQ-034 With data_ready=0, send 0x01..0x05 -> data_valid=1 after the first byte; overrun pulses once, at the 5th stop sample. Then with data_ready=1 -> pops return 0x01,0x02,0x03,0x04, then data_valid=0.
REQ-035 Fill the FIFO (4 bytes), then hold data_ready=1 while the 5th byte's stop sample occurs -> no overrun; the 5th byte is read last; the count stays 4 on the push/pop cycle.
REQ-036 Assert reset during bit 3 of a frame, release, then send 0x3C -> all outputs 0 during reset; only 0x3C is received; no frame_err.

Source files
------------

// File: rtl/uart_rx_if.sv
// Receive-side handshake of uart_rx: byte stream out, ready back, error pulses.
interface uart_rx_if;
  logic       data_valid;
  logic [7:0] data;
  logic       data_ready;
  logic       frame_err;
  logic       overrun;

  modport master (output data_valid, data, frame_err, overrun, input data_ready);
  modport slave  (input data_valid, data, frame_err, overrun, output data_ready);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling, glitch rejection and a small receive FIFO.
module uart_rx #(
  parameter int clks_per_bit = 216,
  parameter int fifo_depth   = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  uart_rx_if.master  bus
);

  localparam int CNT_W  = $clog2(clks_per_bit + 1);
  localparam int PTR_W  = $clog2(fifo_depth);
  localparam int FILL_W = $clog2(fifo_depth + 1);

  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(clks_per_bit);
  localparam logic [CNT_W-1:0]  HALF_CNT = CNT_W'(clks_per_bit / 2);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
  localparam logic [FILL_W-1:0] FILL_ONE = FILL_W'(1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(fifo_depth);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic              rx_meta, rxs;
  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic [2:0]        bit_idx, bit_nx;
  logic [7:0]        shreg, sh_nx;

  logic [7:0]        mem [fifo_depth];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [FILL_W-1:0] count;
  logic              full, pop, push, ferr_nx, ovr_nx;
  logic              ferr_q, ovr_q;

  // Stage: two-flop synchronizer, idles high so reset never looks like a start edge
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  // Stage: frame FSM state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      bit_idx <= bit_nx;
      shreg   <= sh_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt + CNT_ONE;
    bit_nx   = bit_idx;
    sh_nx    = shreg;
    case (state)
      IDLE: begin
        cnt_nx = '0;
        if (!rxs) state_nx = START;
      end
      START: begin
        if (cnt == HALF_CNT) begin
          cnt_nx   = '0;
          state_nx = rxs ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == FULL_CNT) begin
          cnt_nx = '0;
          sh_nx  = {rxs, shreg[7:1]};
          bit_nx = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_nx = STOP;
        end
      end
      STOP: begin
        if (cnt == FULL_CNT) begin
          cnt_nx   = '0;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // A full FIFO still accepts the byte when the head leaves in the same cycle
  always_comb begin
    push    = 1'b0;
    ferr_nx = 1'b0;
    ovr_nx  = 1'b0;
    if (state == STOP && cnt == FULL_CNT) begin
      if (!rxs)               ferr_nx = 1'b1;
      else if (!full || pop)  push    = 1'b1;
      else                    ovr_nx  = 1'b1;
    end
  end

  assign full = (count == FILL_MAX);
  assign pop  = bus.data_valid && bus.data_ready;

  // Stage: receive FIFO storage and pointers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < fifo_depth; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= shreg;
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (pop) rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + FILL_ONE;
        2'b01:   count <= count - FILL_ONE;
        default: count <= count;
      endcase
    end
  end

  // Stage: registered error pulses
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ferr_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      ferr_q <= ferr_nx;
      ovr_q  <= ovr_nx;
    end
  end

  assign bus.data_valid = (count != '0);
  assign bus.data       = mem[rd_ptr];
  assign bus.frame_err  = ferr_q;
  assign bus.overrun    = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: 8N1 frames at 217 cycles/bit, FIFO fill/overrun, errors, reset abort.
module tb_uart_rx;

  localparam int BIT_CYC = 217;
  // start seen after 2 sync flops + 1 IDLE cycle, 109 START cycles, then 9 samples 217 apart
  localparam int STOP_LAT = 2065;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic rx    = 1'b1;

  uart_rx_if bus();

  uart_rx dut (
    .clock (clock),
    .reset (reset),
    .rx    (rx),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  int         ferr_cnt  = 0;
  int         ovr_cnt   = 0;
  int         rise_cnt  = 0;
  int         last_rise = 0;
  logic       dv_prev   = 1'b0;
  logic [7:0] popped [$];

  always @(negedge clock) begin
    if (bus.frame_err === 1'b1) ferr_cnt++;
    if (bus.overrun === 1'b1) ovr_cnt++;
    if (bus.data_valid === 1'b1 && !dv_prev) begin
      rise_cnt++;
      last_rise = cyc;
    end
    dv_prev = (bus.data_valid === 1'b1);
    if (bus.data_valid === 1'b1 && bus.data_ready === 1'b1) popped.push_back(bus.data);
  end

  int b_ferr, b_ovr, b_rise, b_pop, t_start;

  task automatic mark();
    b_ferr = ferr_cnt;
    b_ovr  = ovr_cnt;
    b_rise = rise_cnt;
    b_pop  = popped.size();
  endtask

  function automatic logic [31:0] pop_at(input int i);
    if (b_pop + i < popped.size()) return {24'h0, popped[b_pop + i]};
    return 32'hDEAD;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Called at posedge+1; bit i begins right after posedge t_start + i*BIT_CYC
  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    logic [9:0] frame;
    frame   = {stop_bit, b, 1'b0};
    t_start = cyc;
    for (int i = 0; i < 10; i++) begin
      rx = frame[i];
      idle(BIT_CYC);
    end
    rx = 1'b1;
  endtask

  initial begin
    bus.data_ready = 1'b0;
    idle(5);
    check("rst_valid", {31'h0, bus.data_valid}, 32'h0);
    check("rst_data",  {24'h0, bus.data},       32'h0);
    check("rst_ferr",  {31'h0, bus.frame_err},  32'h0);
    check("rst_ovr",   {31'h0, bus.overrun},    32'h0);
    reset = 1'b1;
    idle(5);

    // single 0x55 frame, consumer always ready
    bus.data_ready = 1'b1;
    mark();
    send_byte(8'h55, 1'b1);
    idle(20);
    check("b55_count",   popped.size() - b_pop, 32'd1);
    check("b55_data",    pop_at(0), 32'h55);
    check("b55_rises",   rise_cnt - b_rise, 32'd1);
    check("b55_latency", last_rise - t_start, STOP_LAT);
    check("b55_ferr",    ferr_cnt - b_ferr, 32'd0);
    check("b55_ovr",     ovr_cnt - b_ovr, 32'd0);

    // short low glitch must be rejected
    mark();
    rx = 1'b0;
    idle(50);
    rx = 1'b1;
    idle(400);
    check("glitch_rises", rise_cnt - b_rise, 32'd0);
    check("glitch_ferr",  ferr_cnt - b_ferr, 32'd0);
    check("glitch_ovr",   ovr_cnt - b_ovr, 32'd0);

    // bad stop bit
    mark();
    send_byte(8'hA3, 1'b0);
    idle(400);
    check("ferr_pulses", ferr_cnt - b_ferr, 32'd1);
    check("ferr_rises",  rise_cnt - b_rise, 32'd0);
    check("ferr_ovr",    ovr_cnt - b_ovr, 32'd0);

    // fill with consumer stalled, fifth byte overruns
    bus.data_ready = 1'b0;
    mark();
    send_byte(8'h01, 1'b1);
    check("ovr_valid1", {31'h0, bus.data_valid}, 32'h1);
    check("ovr_head1",  {24'h0, bus.data}, 32'h01);
    send_byte(8'h02, 1'b1);
    send_byte(8'h03, 1'b1);
    send_byte(8'h04, 1'b1);
    check("ovr_before5", ovr_cnt - b_ovr, 32'd0);
    send_byte(8'h05, 1'b1);
    check("ovr_after5", ovr_cnt - b_ovr, 32'd1);
    bus.data_ready = 1'b1;
    idle(20);
    check("ovr_popcnt", popped.size() - b_pop, 32'd4);
    for (int i = 0; i < 4; i++) check($sformatf("ovr_pop%0d", i), pop_at(i), 32'(i + 1));
    check("ovr_drained", {31'h0, bus.data_valid}, 32'h0);
    check("ovr_ferr",    ferr_cnt - b_ferr, 32'd0);

    // full FIFO, pop coincides with the fifth stop sample
    bus.data_ready = 1'b0;
    mark();
    send_byte(8'h10, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h12, 1'b1);
    send_byte(8'h13, 1'b1);
    fork
      send_byte(8'h14, 1'b1);
      begin
        idle(STOP_LAT - 1);
        bus.data_ready = 1'b1;
        idle(1);
        bus.data_ready = 1'b0;
        check("pp_count", 32'(dut.count), 32'd4);
        check("pp_first", pop_at(0), 32'h10);
      end
    join
    check("pp_ovr", ovr_cnt - b_ovr, 32'd0);
    bus.data_ready = 1'b1;
    idle(20);
    check("pp_popcnt", popped.size() - b_pop, 32'd5);
    for (int i = 1; i < 5; i++) check($sformatf("pp_pop%0d", i), pop_at(i), 32'h10 + 32'(i));

    // reset during bit 3 aborts the frame and empties the FIFO
    bus.data_ready = 1'b0;
    send_byte(8'h77, 1'b1);
    check("ab_prefill", {31'h0, bus.data_valid}, 32'h1);
    fork
      send_byte(8'h99, 1'b1);
      begin
        idle(3 * BIT_CYC + 100);
        reset = 1'b0;
        idle(3);
        check("ab_valid", {31'h0, bus.data_valid}, 32'h0);
        check("ab_data",  {24'h0, bus.data},       32'h0);
        check("ab_ferr",  {31'h0, bus.frame_err},  32'h0);
        check("ab_ovr",   {31'h0, bus.overrun},    32'h0);
      end
    join
    idle(5);
    reset = 1'b1;
    idle(5);
    bus.data_ready = 1'b1;
    mark();
    send_byte(8'h3C, 1'b1);
    idle(400);
    check("ab_popcnt", popped.size() - b_pop, 32'd1);
    check("ab_byte",   pop_at(0), 32'h3C);
    check("ab_ferr2",  ferr_cnt - b_ferr, 32'd0);
    check("ab_ovr2",   ovr_cnt - b_ovr, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
